mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store front-end between the multi-cycle CPU datapath and data_ram.
//  - Takes byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests.
//  - Turns them into data_ram word address, byte write enables and replicated store data.
//  - Waits out the RAM's 1-cycle synchronous read, then aligns and sign/zero-extends load data.
//  - Returns one response per request over a valid/ready handshake.
// PARAMETERS
//  BYTE_ADDR_W   7   byte address width; the RAM word address is BYTE_ADDR_W-2 = 5 bits (32 words)
//  ERR_ON_MISAL  1   1: misaligned or illegal-size requests complete with resp_err and no RAM access
// PORTS
//  clk          in   1   single clock, all state on posedge
//  resetn       in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   unit idle, can accept a request
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed   in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr     in   7   byte address
//  req_wdata    in   32  store data, right-justified
//  resp_valid   out  1   response present
//  resp_ready   in   1   consumer takes the response
//  resp_rdata   out  32  extended load data; 0 for stores and errors
//  resp_err     out  1   misaligned or illegal request
//  ram_wen      out  4   to data_ram wen (bit i = byte lane i)
//  ram_addr     out  5   to data_ram addr (= req_addr[6:2])
//  ram_wdata    out  32  to data_ram wdata
//  ram_rdata    in   32  from data_ram rdata; valid the cycle after a wen==0 edge
// BEHAVIOUR
//  Reset values
//  - state=IDLE, req_ready=1.
//  - resp_valid=0, resp_err=0, resp_rdata=0.
//  - ram_wen=0, ram_addr=0, ram_wdata=0.
//  - ram_wen, ram_addr and ram_wdata are registered outputs.
//  FSM: IDLE -> ISSUE -> (store: RESP | load: WAIT -> RESP) -> IDLE. Error path: IDLE -> RESP.
//  - req_ready = (state==IDLE). Accept when req_valid && req_ready at posedge E0.
//    The accepting edge latches we, size, signed, addr[1:0] and wdata.
//  - ISSUE (cycle 1): ram_addr = addr[6:2].
//    - Store: byte lane = addr[1:0], byte 0 = bits[7:0] (little-endian).
//      - ram_wen: byte 1<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
//      - ram_wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//    - Load: ram_wen=0.
//    - RAM acts at edge E1.
//  - ram_wen is nonzero only during ISSUE of a store. It returns to 0 on the next edge.
//  - ram_addr and ram_wdata hold their last values outside ISSUE.
//  - WAIT (cycle 2, loads only): sample ram_rdata at E2.
//    - Select: byte rdata[8*a+7:8*a]; half a[1]?rdata[31:16]:rdata[15:0].
//    - Extend to 32 bits per req_signed. For a word load req_signed is ignored.
//    - Register the result into resp_rdata.
//  - RESP: resp_valid=1; resp_rdata and resp_err stay stable until resp_valid && resp_ready.
//    - Handshake edge clears resp_valid and returns to IDLE.
//    - The next request can be accepted one cycle later (no back-to-back accept in RESP).
//  - Latency from accept edge to first resp_valid cycle:
//    - store: 2 cycles (resp_valid in cycle 2, RESP entered at E1);
//    - load: 3 cycles (resp_valid in cycle 3, RESP entered at E2);
//    - error: 1 cycle.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//    - With ERR_ON_MISAL=1: go IDLE->RESP, resp_err=1, resp_rdata=0, no RAM cycle (ram_wen stays 0).
//    - With ERR_ON_MISAL=0: force the address aligned (clear the low bits), resp_err=0; size 11 is treated as word.
//  - Stores complete with resp_rdata=0, resp_err=0.
//  - req_valid outside IDLE is ignored. Request inputs need only be stable on the accept edge.
//  - Async reset at any point:
//    - Immediately forces IDLE, ram_wen=0, resp_valid=0.
//    - The in-flight request is dropped and no response is produced.
//    - A store reset during ISSUE before E1 does not write.
// TESTING (data_ram initialised DM[i]=i+1)
//  1 LW addr 0x0C after reset -> ram_addr=3, ram_wen=0; resp_valid 3 cycles after accept; resp_rdata=0x00000004, err=0.
//  2 SB 0xAB @0x09 -> ISSUE ram_wen=0010, ram_wdata=0xABABABAB; then:
//    - LW 0x08 -> 0x0000AB03;
//    - LB 0x09 -> 0xFFFFFFAB;
//    - LBU 0x09 -> 0x000000AB.
//  3 SH 0x8001 @0x12 -> ram_wen=1100, ram_wdata=0x80018001; then:
//    - LH 0x12 -> 0xFFFF8001;
//    - LHU 0x12 -> 0x00008001;
//    - LW 0x10 -> 0x80010005.
//  4 LW @0x06 and SH @0x03 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, ram_wen never nonzero, DM unchanged.
//  5 LW 0x00 with resp_ready low 3 cycles -> resp_valid and resp_rdata=0x00000001 held stable, req_ready=0 throughout.
//    A req_valid pulse in that window is not accepted.
//  6 resetn low during WAIT of LW 0x04 -> next cycle state IDLE, resp_valid=0, req_ready=1, no response.
//    resetn low during ISSUE of SW before the edge -> that word unchanged on readback.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front-end between the multi-cycle CPU datapath and a data RAM
// with a one-cycle synchronous read port.
//
// It accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests and turns each
// one into a RAM word address, per-lane byte write enables and replicated store
// data. For loads it waits out the RAM read latency, then selects the addressed
// byte or half-word and sign- or zero-extends it. Exactly one response is
// returned per accepted request over a valid/ready handshake.
//
// Sequence of states for one request:
//   IDLE -> ISSUE -> RESP             store
//   IDLE -> ISSUE -> WAIT -> RESP     load
//   IDLE -> RESP                      misaligned / illegal (ERR_ON_MISAL=1)
//
// Ports
//   clk         single clock, all state on posedge
//   resetn      asynchronous active-low reset
//   req_valid   request present
//   req_ready   unit idle, able to accept a request
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  loads only: 1 = sign-extend, 0 = zero-extend
//   req_addr    byte address
//   req_wdata   store data, right-justified
//   resp_valid  response present
//   resp_ready  consumer takes the response
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    misaligned or illegal request
//   ram_wen     RAM byte-lane write enables (bit i = byte lane i), registered
//   ram_addr    RAM word address, registered
//   ram_wdata   RAM write data, registered
//   ram_rdata   RAM read data, valid the cycle after a read edge
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int BYTE_ADDR_W  = 7,
  parameter bit ERR_ON_MISAL = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  // request channel
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  // response channel
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  // data RAM port
  output logic [3:0]             ram_wen,
  output logic [BYTE_ADDR_W-3:0] ram_addr,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t state;

  // Request attributes captured on the accepting edge; the request inputs are
  // only guaranteed stable on that edge.
  logic       we_q;
  logic [1:0] size_q;
  logic       signed_q;
  logic [1:0] lo_q;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, looks at the live request inputs)
  // ---------------------------------------------------------------------------
  logic       misal;
  logic [1:0] eff_size;
  logic [1:0] eff_lo;
  logic [3:0] st_lanes;
  logic [31:0] st_data;

  // NOTE: every signal driven from always_comb gets a default at the top of the
  // block so no path can leave it unassigned and infer a latch.
  always_comb begin
    misal    = 1'b0;
    eff_size = req_size;
    eff_lo   = req_addr[1:0];
    st_lanes = 4'b0000;
    st_data  = req_wdata;

    unique case (req_size)
      SZ_BYTE: misal = 1'b0;
      SZ_HALF: misal = req_addr[0];
      SZ_WORD: misal = (req_addr[1:0] != 2'b00);
      SZ_ILL:  misal = 1'b1;
      default: misal = 1'b1;
    endcase

    // With error reporting disabled an illegal size behaves like a word, and
    // the low address bits are forced to the natural alignment of the size.
    if (req_size == SZ_ILL) begin
      eff_size = SZ_WORD;
    end

    unique case (eff_size)
      SZ_BYTE: eff_lo = req_addr[1:0];
      SZ_HALF: eff_lo = {req_addr[1], 1'b0};
      default: eff_lo = 2'b00;
    endcase

    // Little-endian lane selection and data replication so the addressed lane
    // always carries the right-justified store data.
    unique case (eff_size)
      SZ_BYTE: begin
        st_lanes = 4'b0001 << eff_lo;
        st_data  = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_lanes = eff_lo[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{req_wdata[15:0]}};
      end
      default: begin
        st_lanes = 4'b1111;
        st_data  = req_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension (uses the latched request attributes and
  // the RAM read data present during WAIT)
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    byte_sel = ram_rdata[7:0];
    unique case (lo_q)
      2'd0: byte_sel = ram_rdata[7:0];
      2'd1: byte_sel = ram_rdata[15:8];
      2'd2: byte_sel = ram_rdata[23:16];
      2'd3: byte_sel = ram_rdata[31:24];
      default: byte_sel = ram_rdata[7:0];
    endcase

    half_sel = lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    // Word loads ignore the signed flag.
    unique case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = ram_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  // NOTE: the asynchronous reset clears every register, including ram_wen, so a
  // store interrupted during ISSUE never reaches the RAM edge with lanes enabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      lo_q       <= 2'b00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      ram_wen    <= 4'b0000;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= eff_size;
            signed_q <= req_signed;
            lo_q     <= eff_lo;
            if (ERR_ON_MISAL && misal) begin
              // Error completes without touching the RAM.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              // RAM port outputs are set up now so they are presented
              // throughout ISSUE and the RAM acts on the following edge.
              state    <= ISSUE;
              ram_addr <= req_addr[BYTE_ADDR_W-1:2];
              if (req_we) begin
                ram_wen   <= st_lanes;
                ram_wdata <= st_data;
              end else begin
                ram_wen <= 4'b0000;
              end
            end
          end
        end

        ISSUE: begin
          // The RAM performs its access on this edge; write strobes last
          // exactly one cycle.
          ram_wen <= 4'b0000;
          if (we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          // Read data from the ISSUE edge is on ram_rdata now.
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_ext;
        end

        RESP: begin
          // Response held stable until taken; no accept in this cycle.
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);

endmodule
